// File: rtl/req_encoder_8to3.sv
// Sequential 8-to-3 request encoder: latches request lines into a pending register and
// emits one pending index per valid/ready handshake, using fixed or rotating priority.
module req_encoder_8to3 #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] in,
    output logic [2:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] pending,
    output logic       dropped
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_r, state_next_s;
    logic [7:0] pending_r, pending_next_s;
    logic [2:0] out_r, out_next_s;
    logic       out_valid_r, out_valid_next_s;
    logic       dropped_r, dropped_next_s;
    logic [2:0] ptr_r, ptr_next_s;
    logic [2:0] sel_idx_s;
    logic       sel_any_s;
    logic       take_s;
    logic [7:0] take_mask_s;

    // Highest set index wins; later loop iterations override earlier ones.
    function automatic logic [2:0] pick_fixed(input logic [7:0] p);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (p[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Search downward from ptr with wrap; offset 0 (ptr itself) is evaluated last so it wins.
    function automatic logic [2:0] pick_rr(input logic [7:0] p, input logic [2:0] ptr);
        logic [2:0] idx;
        logic [2:0] j;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            j = ptr - 3'(i);
            if (p[j]) begin
                idx = j;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Index selection from the registered pending set only.
    always_comb begin
        sel_any_s = |pending_r;
        if (ROUND_ROBIN) begin
            sel_idx_s = pick_rr(pending_r, ptr_r);
        end else begin
            sel_idx_s = pick_fixed(pending_r);
        end
    end

    // Handshake state machine and next values of every registered output.
    always_comb begin
        state_next_s = state_r;
        take_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (sel_any_s) begin
                    take_s       = 1'b1;
                    state_next_s = HOLD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (sel_any_s) begin
                        take_s       = 1'b1;
                        state_next_s = HOLD;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        take_mask_s      = take_s ? (8'h01 << sel_idx_s) : 8'h00;
        // A fresh set overrides a take of the same bit, so a re-request stays pending.
        pending_next_s   = (pending_r & ~take_mask_s) | (enable ? in : 8'h00);
        dropped_next_s   = enable & (|(in & pending_r & ~take_mask_s));
        out_next_s       = take_s ? sel_idx_s : out_r;
        ptr_next_s       = take_s ? (sel_idx_s - 3'd1) : ptr_r;
        out_valid_next_s = (state_next_s == HOLD);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pending_r   <= 8'h00;
            out_r       <= 3'd0;
            out_valid_r <= 1'b0;
            dropped_r   <= 1'b0;
            ptr_r       <= 3'd7;
        end else begin
            state_r     <= state_next_s;
            pending_r   <= pending_next_s;
            out_r       <= out_next_s;
            out_valid_r <= out_valid_next_s;
            dropped_r   <= dropped_next_s;
            ptr_r       <= ptr_next_s;
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign pending   = pending_r;
    assign dropped   = dropped_r;

endmodule
